fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle decode/execute datapath.
- Owns the program counter and drives the combinational instruction-memory read address.
- Latches each fetched word plus PC+4 into an IF/ID output register consumed by decode.
- Handles stall, redirect (branch/jump target from downstream), halt detection and a fetched-instruction counter.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and state encoding for the fetch stage
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [5:0]  HALT_OPCODE       = 6'b111111;
    localparam logic [31:0] HALT_WORD_DEFAULT = {HALT_OPCODE, 26'h0};
    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_t;

    // Word-align an address; the low two bits of a target are don't-care.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with load, hold and bubble
import fetch_stage_pkg::*;

module if_id_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    // Bubble wins over load; neither asserted means hold. A bubble keeps id_pc4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr <= NOP_WORD;
            id_pc4   <= 32'h0;
            id_valid <= 1'b0;
        end else if (bubble) begin
            id_instr <= NOP_WORD;
            id_valid <= 1'b0;
        end else if (load) begin
            id_instr <= instr_in;
            id_pc4   <= pc4_in;
            id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: pc, fetch FSM, IF/ID register, counter
import fetch_stage_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d;
    logic [31:0]  pc_plus4;
    logic         load, bubble, cnt_inc;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign halted    = (state == ST_HALTED);

    // State, pc and counter registers; the counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            if (cnt_inc && (fetch_count != {CNT_W{1'b1}}))
                fetch_count <= fetch_count + 1'b1;
        end
    end

    // Next-state and IF/ID control: redirect beats stall beats normal fetch.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        load    = 1'b0;
        bubble  = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_d   = align_pc(redirect_pc);
                    bubble = 1'b1;
                end else if (!stall) begin
                    if (imem_data == HALT_WORD) begin
                        bubble  = 1'b1;
                        state_d = ST_HALTED;
                    end else begin
                        load    = 1'b1;
                        pc_d    = pc_plus4;
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                bubble = 1'b1;
                if (redirect) begin
                    pc_d    = align_pc(redirect_pc);
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .bubble   (bubble),
        .instr_in (imem_data),
        .pc4_in   (pc_plus4),
        .id_instr (id_instr),
        .id_pc4   (id_pc4),
        .id_valid (id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam int          CNT_W = 2;
    localparam logic [31:0] HALT  = 32'hFC00_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [31:0]      id_instr;
    logic [31:0]      id_pc4;
    logic             id_valid;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (HALT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    // Combinational instruction memory.
    always_comb begin
        case (imem_addr)
            32'h0000_0000: imem_data = 32'h2001_0005;
            32'h0000_0004: imem_data = 32'h2002_0007;
            32'h0000_0010: imem_data = HALT;
            default:       imem_data = 32'h2400_0000 | {16'h0, imem_addr[15:0]};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid, input logic [CNT_W-1:0] cnt);
        check({tag, ".addr"},  imem_addr, addr);
        check({tag, ".instr"}, id_instr, instr);
        check({tag, ".pc4"},   id_pc4, pc4);
        check({tag, ".valid"}, {31'h0, id_valid}, {31'h0, valid});
        check({tag, ".cnt"},   {30'h0, fetch_count}, {30'h0, cnt});
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #12;
        check_if("reset", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
        check("reset.halted", {31'h0, halted}, 32'h0);
        rst_n = 1'b1;

        step();
        check("boot.addr", imem_addr, 32'h0);
        check("boot.valid", {31'h0, id_valid}, 32'h0);

        step();
        check_if("f0", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 2'd1);
        step();
        check_if("f4", 32'h8, 32'h2002_0007, 32'h8, 1'b1, 2'd2);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_if("stall", 32'h8, 32'h2002_0007, 32'h8, 1'b1, 2'd2);
        end
        stall = 1'b0;
        step();
        check_if("f8", 32'hC, 32'h2400_0008, 32'hC, 1'b1, 2'd3);

        redirect = 1'b1; redirect_pc = 32'h0000_0043; stall = 1'b1;
        step();
        check("redir.addr", imem_addr, 32'h40);
        check("redir.instr", id_instr, 32'h0);
        check("redir.valid", {31'h0, id_valid}, 32'h0);
        check("redir.cnt", {30'h0, fetch_count}, 32'd3);
        redirect = 1'b0; stall = 1'b0;
        step();
        check_if("f40sat", 32'h44, 32'h2400_0040, 32'h44, 1'b1, 2'd3);

        redirect = 1'b1; redirect_pc = 32'h10;
        step();
        check("to10.addr", imem_addr, 32'h10);
        redirect = 1'b0;
        step();
        check("halt.halted", {31'h0, halted}, 32'h1);
        check_if("halt", 32'h10, 32'h0, 32'h44, 1'b0, 2'd3);
        stall = 1'b1;
        step();
        stall = 1'b0;
        step();
        check("halt2.halted", {31'h0, halted}, 32'h1);
        check_if("halt2", 32'h10, 32'h0, 32'h44, 1'b0, 2'd3);

        redirect = 1'b1; redirect_pc = 32'h20; stall = 1'b1;
        step();
        check("unhalt.halted", {31'h0, halted}, 32'h0);
        check("unhalt.addr", imem_addr, 32'h20);
        check("unhalt.valid", {31'h0, id_valid}, 32'h0);
        redirect = 1'b0; stall = 1'b0;
        step();
        check_if("f20", 32'h24, 32'h2400_0020, 32'h24, 1'b1, 2'd3);

        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        check("towrap.addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        check_if("wrap", 32'h0, 32'h2400_FFFC, 32'h0, 1'b1, 2'd3);

        redirect = 1'b1; redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        step();
        check("halt3.halted", {31'h0, halted}, 32'h1);

        #3 rst_n = 1'b0;
        #1;
        check("areset.halted", {31'h0, halted}, 32'h0);
        check_if("areset", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
        #2 rst_n = 1'b1;

        step();
        check("reboot.addr", imem_addr, 32'h0);
        check("reboot.valid", {31'h0, id_valid}, 32'h0);
        step();
        check_if("refetch", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
